// File: rtl/pipe_stage7_pkg.sv
// pipe_stage7_pkg -- shared definitions for the pipe_stage7 output stage.
//   WIDTH          fp16 element width
//   parallel_size  accumulator rows per tile
//   tile_size      elements per row
//   LANES          elements per output beat
//   state_t        stage FSM states (IDLE, STREAM, DONE)
//   beat_w()       width of a beat index for a given tile/lane split
package pipe_stage7_pkg;

  localparam int WIDTH         = 16;
  localparam int parallel_size = 3;
  localparam int tile_size     = 128;
  localparam int LANES         = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // A single-beat row still gets a 1-bit index so no zero-width vectors appear.
  function automatic int beat_w(input int tile, input int lanes);
    return (tile / lanes > 1) ? $clog2(tile / lanes) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage7_if.sv
// pipe_stage7_if -- valid/ready beat stream leaving pipe_stage7.
//   out_valid_o  beat valid                (master -> slave)
//   out_ready_i  downstream ready          (slave -> master)
//   out_data_o   LANES x WIDTH payload, lane 0 = lowest element index
//   out_row_o    row of the current beat
//   out_beat_o   beat index within the row
//   out_last_o   final beat of the tile
interface pipe_stage7_if #(
  parameter int WIDTH  = pipe_stage7_pkg::WIDTH,
  parameter int LANES  = pipe_stage7_pkg::LANES,
  parameter int BEAT_W = pipe_stage7_pkg::beat_w(pipe_stage7_pkg::tile_size, pipe_stage7_pkg::LANES)
);
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [LANES-1:0][WIDTH-1:0] out_data_o;
  logic [1:0]                  out_row_o;
  logic [BEAT_W-1:0]           out_beat_o;
  logic                        out_last_o;

  modport master (
    output out_valid_o, out_data_o, out_row_o, out_beat_o, out_last_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o, out_data_o, out_row_o, out_beat_o, out_last_o,
    output out_ready_i
  );
endinterface

// File: rtl/new_fp16_mul.sv
// new_fp16_mul -- combinational IEEE half-precision multiplier.
//   operands_i  {a, b}, two fp16 operands (a in the upper half)
//   result_o    a * b, round-to-nearest-even
// Subnormal inputs and results are flushed to signed zero; overflow gives
// signed infinity; any NaN input or inf * 0 gives the quiet NaN 0x7E00.
module new_fp16_mul (
  input  logic [31:0] operands_i,
  output logic [15:0] result_o
);

  logic              sa, sb, sign;
  logic [4:0]        ea, eb;
  logic [9:0]        ma, mb, mant;
  logic [21:0]       prod;
  logic [10:0]       mant_r;
  logic              guard, sticky, round_up;
  logic signed [6:0] exp_sum, exp_fin;
  logic              nan_in, inf_in, zero_in;

  always_comb begin
    sa   = operands_i[31];
    ea   = operands_i[30:26];
    ma   = operands_i[25:16];
    sb   = operands_i[15];
    eb   = operands_i[14:10];
    mb   = operands_i[9:0];
    sign = sa ^ sb;

    nan_in  = ((ea == 5'h1F) && (ma != 10'd0)) || ((eb == 5'h1F) && (mb != 10'd0));
    inf_in  = (ea == 5'h1F) || (eb == 5'h1F);
    zero_in = (ea == 5'h00) || (eb == 5'h00);

    prod    = {11'd0, 1'b1, ma} * {11'd0, 1'b1, mb};
    exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'sd15;

    // The significand product lies in [1,4); normalise to [1,2).
    if (prod[21]) begin
      mant    = prod[20:11];
      guard   = prod[10];
      sticky  = |prod[9:0];
      exp_sum = exp_sum + 7'sd1;
    end else begin
      mant    = prod[19:10];
      guard   = prod[9];
      sticky  = |prod[8:0];
    end

    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {10'd0, round_up};
    // A rounding carry out of the mantissa leaves mant_r[9:0] at zero.
    exp_fin  = exp_sum + (mant_r[10] ? 7'sd1 : 7'sd0);

    if (nan_in) begin
      result_o = 16'h7E00;
    end else if (inf_in) begin
      result_o = zero_in ? 16'h7E00 : {sign, 5'h1F, 10'd0};
    end else if (zero_in) begin
      result_o = {sign, 15'd0};
    end else if (exp_fin >= 7'sd31) begin
      result_o = {sign, 5'h1F, 10'd0};
    end else if (exp_fin <= 7'sd0) begin
      result_o = {sign, 15'd0};
    end else begin
      result_o = {sign, exp_fin[4:0], mant_r[9:0]};
    end
  end

endmodule

// File: rtl/pipe_stage7.sv
// pipe_stage7 -- captures an accumulator tile and streams it out as
// LANES-wide beats in row-major order, optionally scaled per row.
//   clk, rst     clock, asynchronous active-low reset
//   capture_i    load request (upstream finished); ignored unless IDLE
//   acc_i        parallel_size x tile_size fp16 tile
//   scale_i      parallel_size fp16 per-row scales
//   out_if       beat stream (pipe_stage7_if.master)
//   busy_o       FSM in STREAM or DONE
//   done_o       one-cycle pulse after the last beat is accepted
//   drop_o       sticky: a capture arrived while not IDLE
// Build option: define PIPE_STAGE7_SCALE_EN to multiply each element by its
// row scale through new_fp16_mul; otherwise elements pass through raw and
// scale_i is not registered.
module pipe_stage7 #(
  parameter int WIDTH         = pipe_stage7_pkg::WIDTH,
  parameter int parallel_size = pipe_stage7_pkg::parallel_size,
  parameter int tile_size     = pipe_stage7_pkg::tile_size,  // multiple of LANES
  parameter int LANES         = pipe_stage7_pkg::LANES
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          capture_i,
  input  logic [parallel_size-1:0][tile_size-1:0][WIDTH-1:0] acc_i,
  input  logic [parallel_size-1:0][WIDTH-1:0]           scale_i,
  pipe_stage7_if.master                                 out_if,
  output logic                                          busy_o,
  output logic                                          done_o,
  output logic                                          drop_o
);
  import pipe_stage7_pkg::*;

  localparam int BEATS  = tile_size / LANES;
  localparam int BEAT_W = beat_w(tile_size, LANES);
  localparam int ELEM_W = $clog2(tile_size);
  localparam logic [1:0]        LAST_ROW  = 2'(parallel_size - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t state_reg, state_next;

  logic [parallel_size-1:0][tile_size-1:0][WIDTH-1:0] acc_buf_reg;
  logic [1:0]                  row_idx_reg;
  logic [BEAT_W-1:0]           beat_idx_reg;
  logic                        all_loaded_reg;  // last beat already in the output register
  logic                        out_valid_reg, out_last_reg, drop_reg;
  logic [LANES-1:0][WIDTH-1:0] out_data_reg, lane_data;
  logic [1:0]                  out_row_reg;
  logic [BEAT_W-1:0]           out_beat_reg;
  logic                        accept, load_en, fire_last, idx_last;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    load_en    = 1'b0;
    fire_last  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (capture_i) begin
          accept     = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        // fire_last implies all_loaded_reg, so it never coincides with load_en.
        fire_last = out_valid_reg && out_if.out_ready_i && out_last_reg;
        load_en   = (!out_valid_reg || out_if.out_ready_i) && !all_loaded_reg;
        if (fire_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign idx_last = (row_idx_reg == LAST_ROW) && (beat_idx_reg == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_idx_reg    <= '0;
      beat_idx_reg   <= '0;
      all_loaded_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      out_data_reg   <= '0;
      out_row_reg    <= '0;
      out_beat_reg   <= '0;
      drop_reg       <= 1'b0;
    end else begin
      if (capture_i && (state_reg != IDLE)) drop_reg <= 1'b1;
      if (accept) begin
        row_idx_reg    <= '0;
        beat_idx_reg   <= '0;
        all_loaded_reg <= 1'b0;
      end else if (load_en) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= lane_data;
        out_row_reg   <= row_idx_reg;
        out_beat_reg  <= beat_idx_reg;
        out_last_reg  <= idx_last;
        if (idx_last) begin
          all_loaded_reg <= 1'b1;
        end else if (beat_idx_reg == LAST_BEAT) begin
          beat_idx_reg <= '0;
          row_idx_reg  <= row_idx_reg + 2'd1;
        end else begin
          beat_idx_reg <= beat_idx_reg + 1'b1;
        end
      end else if (fire_last) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
    end
  end

  // Tile buffer holds its contents across reset; only the FSM and indices clear.
  always_ff @(posedge clk) begin
    if (accept) acc_buf_reg <= acc_i;
  end

`ifdef PIPE_STAGE7_SCALE_EN
  logic [parallel_size-1:0][WIDTH-1:0] scale_buf_reg;

  always_ff @(posedge clk) begin
    if (accept) scale_buf_reg <= scale_i;
  end
`else
  // scale_i has no consumer in the pass-through build.
  logic unused_scale;
  assign unused_scale = ^scale_i;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [ELEM_W-1:0] elem_idx;
      logic [WIDTH-1:0]  elem;

      assign elem_idx = ELEM_W'(beat_idx_reg * LANES + gi);
      assign elem     = acc_buf_reg[row_idx_reg][elem_idx];
`ifdef PIPE_STAGE7_SCALE_EN
      new_fp16_mul u_mul (
        .operands_i ({elem, scale_buf_reg[row_idx_reg]}),
        .result_o   (lane_data[gi])
      );
`else
      assign lane_data[gi] = elem;
`endif
    end
  endgenerate

  assign out_if.out_valid_o = out_valid_reg;
  assign out_if.out_data_o  = out_data_reg;
  assign out_if.out_row_o   = out_row_reg;
  assign out_if.out_beat_o  = out_beat_reg;
  assign out_if.out_last_o  = out_last_reg;
  assign busy_o = (state_reg != IDLE);
  assign done_o = (state_reg == DONE);
  assign drop_o = drop_reg;

endmodule

// File: tb/tb_pipe_stage7.sv
// tb_pipe_stage7 -- self-checking bench for pipe_stage7 at default parameters.
// Directed per-row vectors from a table, plus randomized tiles checked against
// a real-arithmetic reference with a beat scoreboard.
module tb_pipe_stage7;

  typedef struct {
    logic [127:0] data;
    int           row;
    int           beat;
    bit           last;
  } beat_t;

  typedef struct {
    logic [15:0]      elem;
    logic [2:0][15:0] scale;
    logic [2:0][15:0] expect_v;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic capture = 1'b0;
  logic [2:0][127:0][15:0] acc;
  logic [2:0][15:0]        scale;
  logic busy, done, drop;

  int n_checks = 0;
  int n_fail   = 0;
  beat_t exp_q[$];
  vec_t  vec[5];

  pipe_stage7_if #(.WIDTH(16), .LANES(8), .BEAT_W(4)) out_if ();

  pipe_stage7 #(.WIDTH(16), .parallel_size(3), .tile_size(128), .LANES(8)) dut (
    .clk(clk), .rst(rst), .capture_i(capture), .acc_i(acc), .scale_i(scale),
    .out_if(out_if), .busy_o(busy), .done_o(done), .drop_o(drop)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0][15:0] rows3(input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2);
    logic [2:0][15:0] v;
    v[0] = r0; v[1] = r1; v[2] = r2;
    return v;
  endfunction

`ifdef PIPE_STAGE7_SCALE_EN
  function automatic real fp16_to_real(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    v = 1.0 + real'(int'(h[9:0])) / 1024.0;
    for (int k = 0; k < e - 15; k++) v = v * 2.0;
    for (int k = 0; k < 15 - e; k++) v = v / 2.0;
    return h[15] ? -v : v;
  endfunction

  // Exact for normal results, which the randomized operand ranges guarantee.
  function automatic logic [15:0] real_to_fp16(input real v);
    real a;
    int  e, m;
    bit  s;
    s = (v < 0.0);
    a = s ? -v : v;
    if (a == 0.0) return {s, 15'd0};
    e = 15;
    while (a >= 2.0 && e < 40) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > -10) begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    return {s, 5'(e), 10'(m)};
  endfunction
`endif

  // Expected beat sequence for the current acc/scale, straight from the rules:
  // row-major, LANES consecutive elements per beat, last flag on the final beat.
  function automatic void build_model();
    exp_q.delete();
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 16; b++) begin
        beat_t t;
        for (int l = 0; l < 8; l++) begin
`ifdef PIPE_STAGE7_SCALE_EN
          t.data[l*16 +: 16] = real_to_fp16(fp16_to_real(acc[r][b*8+l]) * fp16_to_real(scale[r]));
`else
          t.data[l*16 +: 16] = acc[r][b*8+l];
`endif
        end
        t.row = r; t.beat = b; t.last = (r == 2) && (b == 15);
        exp_q.push_back(t);
      end
    end
  endfunction

  function automatic void build_const(input logic [2:0][15:0] rowval);
    exp_q.delete();
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 16; b++) begin
        beat_t t;
        t.data = {8{rowval[r]}};
        t.row = r; t.beat = b; t.last = (r == 2) && (b == 15);
        exp_q.push_back(t);
      end
    end
  endfunction

  task automatic randomize_tile();
    logic [15:0] sset [6] = '{16'h3800, 16'h3C00, 16'h4000, 16'h4400, 16'hB800, 16'hC000};
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 128; e++)
        acc[r][e] = {1'($urandom_range(0, 1)), 5'($urandom_range(8, 22)), 10'($urandom_range(0, 1023))};
      scale[r] = sset[$urandom_range(0, 5)];
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after capture.
  task automatic capture_tile(input string tag);
    capture = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    check({tag, "_cap_valid"}, out_if.out_valid_o, 1'b0);
    check({tag, "_cap_busy"}, busy, 1'b1);
  endtask

  // mode 0: ready always 1; mode 1: ready 1010...; mode 2: random ready.
  task automatic stream_tile(input int mode, input int inject_at, input int abort_at, input string tag);
    int cyc, hs;
    bit stalled, injected, rdy;
    logic [127:0] snap_d;
    logic [6:0]   snap_i;
    beat_t t;
    cyc = 0; hs = 0; stalled = 0; injected = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      @(negedge clk);
      capture = 1'b0;
      if (hs == abort_at && out_if.out_valid_o) begin
        rst = 1'b0;
        #1;
        check({tag, "_rst_valid"}, out_if.out_valid_o, 1'b0);
        check({tag, "_rst_busy_done_drop_last"}, {busy, done, drop, out_if.out_last_o}, 4'b0000);
        check({tag, "_rst_idx"}, {out_if.out_row_o, out_if.out_beat_o}, 6'd0);
        check({tag, "_rst_data"}, out_if.out_data_o, 128'd0);
        exp_q.delete();
        @(negedge clk);
        check({tag, "_rst_hold_valid"}, out_if.out_valid_o, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_post_rst_busy"}, busy, 1'b0);
        return;
      end
      if (hs == inject_at && !injected) begin
        capture = 1'b1;
        acc = ~acc;
        injected = 1;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 9) < 7);
      endcase
      out_if.out_ready_i = rdy;
      if (stalled) begin
        check({tag, "_hold_valid"}, out_if.out_valid_o, 1'b1);
        check({tag, "_hold_data"}, out_if.out_data_o, snap_d);
        check({tag, "_hold_idx"}, {out_if.out_row_o, out_if.out_beat_o, out_if.out_last_o}, snap_i);
      end
      if (out_if.out_valid_o && rdy) begin
        t = exp_q.pop_front();
        check($sformatf("%s_data_r%0d_b%0d", tag, t.row, t.beat), out_if.out_data_o, t.data);
        check($sformatf("%s_idx_r%0d_b%0d", tag, t.row, t.beat),
              {out_if.out_row_o, out_if.out_beat_o, out_if.out_last_o},
              {2'(t.row), 4'(t.beat), t.last});
        hs++;
      end
      stalled = out_if.out_valid_o && !rdy;
      snap_d  = out_if.out_data_o;
      snap_i  = {out_if.out_row_o, out_if.out_beat_o, out_if.out_last_o};
      cyc++;
    end
    capture = 1'b0;
    check({tag, "_remaining"}, exp_q.size(), 0);
    check({tag, "_handshakes"}, hs, 48);
    if (mode == 0) check({tag, "_cycles"}, cyc, 48);
    @(negedge clk);
    check({tag, "_done_pulse"}, {done, busy, out_if.out_valid_o}, 3'b110);
    @(negedge clk);
    check({tag, "_done_clear"}, {done, busy}, 2'b00);
  endtask

  initial begin
    vec[0] = '{16'h3C00, rows3(16'h4000, 16'h4000, 16'h4000), rows3(16'h4000, 16'h4000, 16'h4000)};
    vec[1] = '{16'h3C00, rows3(16'h3C00, 16'h3800, 16'hBC00), rows3(16'h3C00, 16'h3800, 16'hBC00)};
    vec[2] = '{16'h3E00, rows3(16'h3E00, 16'h3C01, 16'h4000), rows3(16'h4080, 16'h3E02, 16'h4200)};
    vec[3] = '{16'h7BFF, rows3(16'h4000, 16'h3C00, 16'h0000), rows3(16'h7C00, 16'h7BFF, 16'h0000)};
    vec[4] = '{16'h3C01, rows3(16'h3C01, 16'hBC00, 16'h7C00), rows3(16'h3C02, 16'hBC01, 16'h7C00)};

    out_if.out_ready_i = 1'b0;
    acc = '0;
    scale = '0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {out_if.out_valid_o, out_if.out_last_o, done, drop, busy}, 5'b00000);
    check("reset_data", out_if.out_data_o, 128'd0);
    check("reset_idx", {out_if.out_row_o, out_if.out_beat_o}, 6'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    for (int i = 0; i < 5; i++) begin
      acc   = {384{vec[i].elem}};
      scale = vec[i].scale;
`ifdef PIPE_STAGE7_SCALE_EN
      build_const(vec[i].expect_v);
`else
      build_const({3{vec[i].elem}});
`endif
      capture_tile($sformatf("vec%0d", i));
      stream_tile(0, -1, -1, $sformatf("vec%0d", i));
    end

    randomize_tile(); build_model(); capture_tile("toggle");
    stream_tile(1, -1, -1, "toggle");

    check("drop_before", drop, 1'b0);
    randomize_tile(); build_model(); capture_tile("drop");
    stream_tile(0, 5, -1, "drop");
    check("drop_sticky", drop, 1'b1);
    randomize_tile(); build_model(); capture_tile("after_drop");
    stream_tile(2, -1, -1, "after_drop");
    check("drop_still_set", drop, 1'b1);

    randomize_tile(); build_model(); capture_tile("abort");
    stream_tile(0, -1, 10, "abort");
    randomize_tile(); build_model(); capture_tile("restart");
    stream_tile(0, -1, -1, "restart");

`ifndef PIPE_STAGE7_SCALE_EN
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 128; e++) acc[r][e] = 16'(r * 128 + e);
      scale[r] = 16'h4000;
    end
    build_model(); capture_tile("raw");
    stream_tile(0, -1, -1, "raw");
`endif

    for (int k = 0; k < 3; k++) begin
      randomize_tile(); build_model(); capture_tile($sformatf("rand%0d", k));
      stream_tile(2, -1, -1, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
